uart_fifo_v2: RTL and testbench
===============================

UART_FIFO_V2 -- requirements
Module: uart_fifo_v2

Interface
REQ-001 SHALL have parameter DATA_W, default 8: data word width in bits (1..32).
REQ-002 SHALL have parameter DEPTH, default 128: usable entries, any integer 2..1024; need not be a power of two.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-4: almost-full threshold on occupancy.
REQ-004 SHALL have parameter AE_LEVEL, default 4: almost-empty threshold on occupancy.
REQ-005 SHALL have parameter FWFT, default 0: 0 = registered read data, 1 = first-word-fall-through.
REQ-006 SHALL have ports: clk  in  1  system clock; one clock; all state on its rising edge.
REQ-007 SHALL have ports: rst  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have ports: data_i  in  DATA_W  write data; n_we_i  in  1  write request, active-low; n_re_i  in  1  read request, active-low; n_clr_i  in  1  synchronous clear, active-low.
REQ-009 SHALL have ports: data_o  out  DATA_W  read data; count_o  out  CNT_W  occupancy, CNT_W = clog2(DEPTH+1).
REQ-010 SHALL have ports: p_empty_o, p_full_o, p_afull_o, p_aempty_o  out  1 each  status flags, active-high.
REQ-011 SHALL have ports: p_ovf_o, p_udf_o  out  1 each  sticky overflow/underflow flags, active-high.

Function
REQ-012 Write accepted iff n_we_i=0 and count<DEPTH; data_i stored at write pointer, pointer advances.
REQ-013 Read accepted iff n_re_i=0 and count>0; read pointer advances.
REQ-014 All DEPTH entries SHALL be usable; full when count==DEPTH, empty when count==0; no sacrificial slot.
REQ-015 Pointers SHALL wrap DEPTH-1 -> 0 explicitly (valid for non-power-of-two DEPTH).
REQ-016 count_o: +1 on accepted write only, -1 on accepted read only, unchanged on both or neither; never exceeds DEPTH or underflows.
REQ-017 Simultaneous read+write when full: read accepted, write rejected (count -> DEPTH-1). When empty: write accepted, read rejected (count -> 1).
REQ-018 Flags are registered-state derived, valid same cycle as count_o: p_afull_o = count>=AF_LEVEL, p_aempty_o = count<=AE_LEVEL.
REQ-019 Rejected write (n_we_i=0, full) SHALL set p_ovf_o; rejected read (n_re_i=0, empty) SHALL set p_udf_o; both stay set until n_clr_i or reset.
REQ-020 FWFT=0: data_o updates with head entry on the clock edge accepting a read (1-cycle latency), holds otherwise.
REQ-021 FWFT=1: data_o presents head entry whenever not empty, visible the cycle after the write into an empty FIFO; accepted read exposes next entry next cycle; value undefined-but-stable (last output held) when empty.
REQ-022 n_clr_i=0 SHALL override reads/writes that cycle: pointers, count, sticky flags and data_o to 0 at the next edge; memory contents not cleared.

Reset
REQ-023 rst=0 SHALL asynchronously force pointers=0, count_o=0, p_empty_o=1, p_full_o=0, p_aempty_o=1, p_afull_o=0 (unless AF_LEVEL==0), p_ovf_o=0, p_udf_o=0, data_o=0.
REQ-024 Reset release SHALL be synchronous to clk (externally synchronised); first accepted operation on the first edge after release.
REQ-025 Memory array SHALL NOT be reset.

Structure
REQ-026 Package uart_fifo_pkg SHALL hold clog2 function and default constants (DATA_W, DEPTH, AF/AE levels).
REQ-027 Storage SHALL be a sub-module fifo_dpram (one write port, one read port, registered read) inferable as block RAM; control logic in uart_fifo_v2.
REQ-028 Parameter checks (DEPTH>=2, AE_LEVEL<AF_LEVEL<=DEPTH) SHALL be elaboration-time assertions.

Verification (DEPTH=5, DATA_W=8, AF_LEVEL=4, AE_LEVEL=1)
REQ-029 Write 0x11..0x15, FWFT=0 -> count 5, full=1, afull=1 from 4th; 6th write 0x16 -> ovf=1, count stays 5; five reads -> data_o 0x11..0x15 one cycle after each.
REQ-030 Wrap: 40 interleaved write/read pairs of incrementing bytes -> output order exact, pointers pass 4->0 repeatedly, count never >2.
REQ-031 Full + simultaneous read/write -> count 4, written byte dropped; empty + simultaneous -> count 1, udf=0.
REQ-032 FWFT=1: write 0xA5 to empty -> data_o=0xA5 next cycle with n_re_i=1; read -> empty=1 next cycle.
REQ-033 Read from empty -> udf=1; n_clr_i=0 with count 3 and n_we_i=0 -> count 0, flags cleared, write ignored.
REQ-034 Assert rst=0 mid-burst between edges -> all outputs at reset values immediately, before next clk edge.

Source files
------------

// File: rtl/uart_fifo_pkg.sv
// Shared defaults and a constant clog2 helper for the uart_fifo_v2 family.
// Pure elaboration-time content: no logic, no latency, no flow control.
package uart_fifo_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_DEPTH     = 128;
  localparam int DEF_AF_MARGIN = 4;
  localparam int DEF_AE_LEVEL  = 4;

  // Ceiling log2 usable in parameter expressions; clog2(1) == 0.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_dpram.sv
// Simple dual-port storage, one write and one registered read port; read data one edge after re.
// No flow control: caller guarantees addresses are valid; only the output register is reset/cleared.
module fifo_dpram
  import uart_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = clog2(DEF_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Array left unreset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
    end else if (clr) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/uart_fifo_v2.sv
// Synchronous FIFO, all DEPTH entries usable; read data 1 cycle after read (FWFT=0) or head shown (FWFT=1).
// Writes dropped when full (sticky ovf), reads ignored when empty (sticky udf); active-low clear overrides both.
module uart_fifo_v2
  import uart_fifo_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - DEF_AF_MARGIN,
  parameter int AE_LEVEL = DEF_AE_LEVEL,
  parameter int FWFT     = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_W-1:0]           data_i,
  input  logic                        n_we_i,
  input  logic                        n_re_i,
  input  logic                        n_clr_i,
  output logic [DATA_W-1:0]           data_o,
  output logic [clog2(DEPTH+1)-1:0]   count_o,
  output logic                        p_empty_o,
  output logic                        p_full_o,
  output logic                        p_afull_o,
  output logic                        p_aempty_o,
  output logic                        p_ovf_o,
  output logic                        p_udf_o
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  if (DATA_W < 1 || DATA_W > 32) begin : g_chk_width
    $error("uart_fifo_v2: DATA_W must be 1..32");
  end
  if (DEPTH < 2 || DEPTH > 1024) begin : g_chk_depth
    $error("uart_fifo_v2: DEPTH must be 2..1024");
  end
  if (!(AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH)) begin : g_chk_levels
    $error("uart_fifo_v2: need AE_LEVEL < AF_LEVEL <= DEPTH");
  end

  logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_ptr_nxt, ram_raddr;
  logic [CNT_W-1:0]  count;
  logic              empty, full, clr, wr_acc, rd_acc;
  logic              ovf, udf;
  logic              ram_re, byp_load, byp_sel;
  logic [DATA_W-1:0] byp_dat, ram_dat;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    clr        = !n_clr_i;
    empty      = (count == '0);
    full       = (count == DEPTH_C);
    wr_acc     = !n_we_i && !full;
    rd_acc     = !n_re_i && !empty;
    rd_ptr_nxt = ptr_inc(rd_ptr);
    byp_load   = 1'b0;
    ram_re     = rd_acc;
    ram_raddr  = rd_ptr;
    if (FWFT != 0) begin
      // The next head is either already in RAM, or is the word arriving this cycle and must bypass it.
      byp_load  = wr_acc && (empty || (rd_acc && count == ONE_C));
      ram_re    = rd_acc && (count > ONE_C);
      ram_raddr = rd_ptr_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf     <= 1'b0;
      udf     <= 1'b0;
      byp_sel <= 1'b0;
      byp_dat <= '0;
    end else if (clr) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf     <= 1'b0;
      udf     <= 1'b0;
      byp_sel <= 1'b0;
      byp_dat <= '0;
    end else begin
      if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_acc) rd_ptr <= rd_ptr_nxt;
      if (wr_acc && !rd_acc) begin
        count <= count + ONE_C;
      end else if (rd_acc && !wr_acc) begin
        count <= count - ONE_C;
      end
      if (!n_we_i && full) ovf <= 1'b1;
      // A read paired with a write on an empty FIFO is not treated as an underflow.
      if (!n_re_i && empty && n_we_i) udf <= 1'b1;
      if (byp_load) begin
        byp_sel <= 1'b1;
        byp_dat <= data_i;
      end else if (ram_re) begin
        byp_sel <= 1'b0;
      end
    end
  end

  fifo_dpram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .we    (wr_acc && !clr),
    .waddr (wr_ptr),
    .wdata (data_i),
    .re    (ram_re && !clr),
    .raddr (ram_raddr),
    .rdata (ram_dat)
  );

  assign data_o     = byp_sel ? byp_dat : ram_dat;
  assign count_o    = count;
  assign p_empty_o  = empty;
  assign p_full_o   = full;
  assign p_afull_o  = (count >= AF_C);
  assign p_aempty_o = (count <= AE_C);
  assign p_ovf_o    = ovf;
  assign p_udf_o    = udf;

endmodule

// File: tb/tb_uart_fifo_v2.sv
// Directed bench for uart_fifo_v2 (DEPTH=5): registered-read and FWFT instances checked against a queue model.
module tb_uart_fifo_v2;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] d0, q0, d1, q1;
  logic       n_we0, n_re0, n_clr0, n_we1, n_re1, n_clr1;
  logic [2:0] cnt0, cnt1;
  logic       emp0, ful0, af0, ae0, ovf0, udf0;
  logic       emp1, ful1, af1, ae1, ovf1, udf1;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] sb0[$];
  logic [7:0] sb1[$];
  logic [7:0] m_dout0, m_dout1;
  bit         m_ovf0, m_udf0;

  always #5 clk = ~clk;

  uart_fifo_v2 #(.DATA_W(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1), .FWFT(0)) u_dut0 (
    .clk(clk), .rst(rst), .data_i(d0), .n_we_i(n_we0), .n_re_i(n_re0), .n_clr_i(n_clr0),
    .data_o(q0), .count_o(cnt0), .p_empty_o(emp0), .p_full_o(ful0), .p_afull_o(af0),
    .p_aempty_o(ae0), .p_ovf_o(ovf0), .p_udf_o(udf0)
  );

  uart_fifo_v2 #(.DATA_W(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1), .FWFT(1)) u_dut1 (
    .clk(clk), .rst(rst), .data_i(d1), .n_we_i(n_we1), .n_re_i(n_re1), .n_clr_i(n_clr1),
    .data_o(q1), .count_o(cnt1), .p_empty_o(emp1), .p_full_o(ful1), .p_afull_o(af1),
    .p_aempty_o(ae1), .p_ovf_o(ovf1), .p_udf_o(udf1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all0(input string tag);
    int n;
    n = sb0.size();
    chk({tag, ".count"},  32'(cnt0), 32'(n));
    chk({tag, ".empty"},  32'(emp0), 32'(n == 0));
    chk({tag, ".full"},   32'(ful0), 32'(n == 5));
    chk({tag, ".afull"},  32'(af0),  32'(n >= 4));
    chk({tag, ".aempty"}, 32'(ae0),  32'(n <= 1));
    chk({tag, ".ovf"},    32'(ovf0), 32'(m_ovf0));
    chk({tag, ".udf"},    32'(udf0), 32'(m_udf0));
    chk({tag, ".data"},   32'(q0),   32'(m_dout0));
  endtask

  task automatic check_all1(input string tag);
    int n;
    n = sb1.size();
    chk({tag, ".count1"}, 32'(cnt1), 32'(n));
    chk({tag, ".empty1"}, 32'(emp1), 32'(n == 0));
    chk({tag, ".full1"},  32'(ful1), 32'(n == 5));
    chk({tag, ".data1"},  32'(q1),   32'(m_dout1));
  endtask

  // One clock on the registered-read instance; the model is updated from the request before the edge.
  task automatic step0(input bit we, input bit re, input logic [7:0] d, input string tag);
    int n;
    bit wacc, racc;
    n    = sb0.size();
    wacc = we && (n < 5);
    racc = re && (n > 0);
    if (we && !wacc) m_ovf0 = 1'b1;
    if (re && n == 0 && !we) m_udf0 = 1'b1;
    if (racc) m_dout0 = sb0.pop_front();
    if (wacc) sb0.push_back(d);
    n_we0 = !we;
    n_re0 = !re;
    d0    = d;
    @(posedge clk);
    #1;
    n_we0 = 1'b1;
    n_re0 = 1'b1;
    check_all0(tag);
  endtask

  task automatic clear0(input bit we, input string tag);
    n_clr0 = 1'b0;
    n_we0  = !we;
    d0     = 8'hCC;
    @(posedge clk);
    #1;
    n_clr0 = 1'b1;
    n_we0  = 1'b1;
    sb0.delete();
    m_ovf0  = 1'b0;
    m_udf0  = 1'b0;
    m_dout0 = 8'h00;
    check_all0(tag);
  endtask

  // FWFT instance: after each edge data_o must show the model head, or hold its last value when empty.
  task automatic step1(input bit we, input bit re, input logic [7:0] d, input string tag);
    int n;
    n = sb1.size();
    if (re && n > 0) void'(sb1.pop_front());
    if (we && n < 5) sb1.push_back(d);
    n_we1 = !we;
    n_re1 = !re;
    d1    = d;
    @(posedge clk);
    #1;
    n_we1 = 1'b1;
    n_re1 = 1'b1;
    if (sb1.size() > 0) m_dout1 = sb1[0];
    check_all1(tag);
  endtask

  initial begin
    logic [7:0] b;
    n_we0 = 1'b1; n_re0 = 1'b1; n_clr0 = 1'b1; d0 = 8'h00;
    n_we1 = 1'b1; n_re1 = 1'b1; n_clr1 = 1'b1; d1 = 8'h00;
    m_dout0 = 8'h00; m_dout1 = 8'h00; m_ovf0 = 1'b0; m_udf0 = 1'b0;
    rst = 1'b0;
    #2;
    check_all0("reset");
    check_all1("reset");
    #10;
    rst = 1'b1;

    // Fill to full, overflow, drain in order.
    for (int i = 0; i < 5; i++) step0(1'b1, 1'b0, 8'(8'h11 + i), "fill");
    step0(1'b1, 1'b0, 8'h16, "ovf_write");
    for (int i = 0; i < 5; i++) step0(1'b0, 1'b1, 8'h00, "drain");

    // Underflow then clear with a concurrent write that must be ignored.
    step0(1'b0, 1'b1, 8'h00, "udf_read");
    for (int i = 0; i < 3; i++) step0(1'b1, 1'b0, 8'(8'h21 + i), "pre_clr");
    clear0(1'b1, "clear");

    // Simultaneous read/write at full and at empty.
    for (int i = 0; i < 5; i++) step0(1'b1, 1'b0, 8'(8'h41 + i), "fill2");
    step0(1'b1, 1'b1, 8'hEE, "full_rw");
    for (int i = 0; i < 4; i++) step0(1'b0, 1'b1, 8'h00, "drain2");
    clear0(1'b0, "clear2");
    step0(1'b1, 1'b1, 8'h77, "empty_rw");
    step0(1'b0, 1'b1, 8'h00, "empty_rw_rd");

    // Pointer wrap: 40 write/read pairs of incrementing bytes.
    b = 8'h80;
    for (int i = 0; i < 40; i++) begin
      step0(1'b1, 1'b0, b, "wrap_w");
      step0(1'b0, 1'b1, 8'h00, "wrap_r");
      b = b + 8'h01;
    end

    // First-word-fall-through instance.
    step1(1'b1, 1'b0, 8'hA5, "fwft_wr");
    step1(1'b0, 1'b0, 8'h00, "fwft_hold");
    step1(1'b0, 1'b1, 8'h00, "fwft_rd");
    step1(1'b1, 1'b0, 8'hC1, "fwft_c1");
    step1(1'b1, 1'b1, 8'hC2, "fwft_byp");
    step1(1'b1, 1'b0, 8'hC3, "fwft_c3");
    step1(1'b1, 1'b0, 8'hC4, "fwft_c4");
    for (int i = 0; i < 3; i++) step1(1'b0, 1'b1, 8'h00, "fwft_drain");
    for (int i = 0; i < 12; i++) begin
      step1(1'b1, 1'b0, 8'(8'hD0 + i), "fwft_ww");
      step1(1'b1, 1'b1, 8'(8'hE0 + i), "fwft_rw");
      step1(1'b0, 1'b1, 8'h00, "fwft_rr");
    end

    // Asynchronous reset in the middle of a write burst.
    step0(1'b1, 1'b0, 8'h31, "burst");
    step0(1'b1, 1'b0, 8'h32, "burst");
    n_we0 = 1'b0;
    d0    = 8'h33;
    #2;
    rst = 1'b0;
    #1;
    sb0.delete(); sb1.delete();
    m_ovf0 = 1'b0; m_udf0 = 1'b0; m_dout0 = 8'h00; m_dout1 = 8'h00;
    check_all0("async_rst");
    check_all1("async_rst");
    #3;
    rst   = 1'b1;
    n_we0 = 1'b1;
    @(posedge clk);
    #1;
    step0(1'b1, 1'b0, 8'h5A, "post_rst_w");
    step0(1'b0, 1'b1, 8'h00, "post_rst_r");
    step1(1'b1, 1'b0, 8'h6B, "post_rst_w1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
